// File: rtl/k502_linebuf_sched.sv
// Double-banked sprite line buffer sequencer: the display bank is read and cleared
// behind the beam while the render bank takes read-modify-write sprite pixels.
module k502_linebuf_sched #(
    parameter int XW = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          line_start,
    input  logic          pix_ce,
    input  logic [XW-1:0] disp_x,
    input  logic          clear_en,
    input  logic          prio_mode,
    input  logic          wr_req,
    input  logic [XW-1:0] wr_x,
    input  logic [CW-1:0] wr_col,
    output logic          wr_ack,
    output logic [CW-1:0] pix_out,
    output logic          pix_vld,
    output logic          bank,
    output logic          ovr,
    input  logic          ovr_clr,
    output logic [XW-1:0] ram0_addr,
    output logic          ram0_we,
    output logic [CW-1:0] ram0_d,
    input  logic [CW-1:0] ram0_q,
    output logic [XW-1:0] ram1_addr,
    output logic          ram1_we,
    output logic [CW-1:0] ram1_d,
    input  logic [CW-1:0] ram1_q
);

    typedef enum logic [1:0] {D_IDLE, D_RD, D_CLR} d_state_t;
    typedef enum logic [1:0] {R_IDLE, R_RD, R_WR} r_state_t;

    d_state_t d_st;
    r_state_t r_st;
    logic     pending;
    logic [CW-1:0] r_col;

    // Per-port address/data registers: an idle port keeps its last address
    // even across a bank swap, since ownership changes but the register does not.
    logic [1:0][XW-1:0] addr_r;
    logic [1:0][CW-1:0] data_r;
    logic [1:0]         we;

    logic          blocked, d_acc, r_acc, swap;
    logic          d_we, r_we;
    logic [CW-1:0] d_q, r_q;

    assign d_q = bank ? ram1_q : ram0_q;
    assign r_q = bank ? ram0_q : ram1_q;

    // A LINE_START in the current cycle already blocks new work so that an
    // accept can never coincide with the swap edge.
    assign blocked = pending | line_start;
    assign d_acc   = pix_ce && (d_st == D_IDLE) && !blocked;
    assign r_acc   = wr_req && (r_st == R_IDLE) && !blocked;
    assign swap    = (pending | line_start) && (d_st == D_IDLE) && (r_st == R_IDLE);

    // Render write decision depends on the RAM read data of this cycle.
    assign r_we = (r_st == R_WR) && (r_col != '0) && !(prio_mode && (r_q != '0));
    assign d_we = (d_st == D_CLR) && clear_en;

    assign wr_ack = (r_st == R_WR);

    for (genvar n = 0; n < 2; n++) begin : g_port
        assign we[n] = (bank == 1'(n)) ? d_we : r_we;
    end

    assign ram0_addr = addr_r[0];
    assign ram0_d    = data_r[0];
    assign ram0_we   = we[0];
    assign ram1_addr = addr_r[1];
    assign ram1_d    = data_r[1];
    assign ram1_we   = we[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_st    <= D_IDLE;
            r_st    <= R_IDLE;
            bank    <= 1'b0;
            pending <= 1'b0;
            ovr     <= 1'b0;
            pix_out <= '0;
            pix_vld <= 1'b0;
            r_col   <= '0;
            addr_r  <= '0;
            data_r  <= '0;
        end else begin
            pix_vld <= 1'b0;

            case (d_st)
                D_IDLE:  if (d_acc) d_st <= D_RD;
                D_RD:    d_st <= D_CLR;
                D_CLR: begin
                    d_st    <= D_IDLE;
                    pix_out <= d_q;
                    pix_vld <= 1'b1;
                end
                default: d_st <= D_IDLE;
            endcase

            case (r_st)
                R_IDLE:  if (r_acc) r_st <= R_RD;
                R_RD:    r_st <= R_WR;
                R_WR:    r_st <= R_IDLE;
                default: r_st <= R_IDLE;
            endcase

            if (d_acc) begin
                addr_r[bank] <= disp_x;
                data_r[bank] <= '0;
            end
            if (r_acc) begin
                addr_r[~bank] <= wr_x;
                data_r[~bank] <= wr_col;
                r_col         <= wr_col;
            end

            if (pix_ce && !d_acc)
                ovr <= 1'b1;
            else if (ovr_clr)
                ovr <= 1'b0;

            if (swap) begin
                bank    <= ~bank;
                pending <= 1'b0;
            end else if (line_start) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_k502_linebuf_sched.sv
// Bench for k502_linebuf_sched: directed cycle table, swap/reset sequences, and
// randomized traffic against a transaction-level line-buffer model.
module tb_k502_linebuf_sched;
    localparam int XW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          line_start, pix_ce, clear_en, prio_mode, wr_req, ovr_clr;
    logic [XW-1:0] disp_x, wr_x;
    logic [CW-1:0] wr_col;
    logic          wr_ack, pix_vld, bank, ovr;
    logic [CW-1:0] pix_out;
    logic [XW-1:0] ram0_addr, ram1_addr;
    logic          ram0_we, ram1_we;
    logic [CW-1:0] ram0_d, ram1_d, ram0_q, ram1_q;

    int errors = 0;
    int checks = 0;

    k502_linebuf_sched #(.XW(XW), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .line_start(line_start), .pix_ce(pix_ce),
        .disp_x(disp_x), .clear_en(clear_en), .prio_mode(prio_mode), .wr_req(wr_req),
        .wr_x(wr_x), .wr_col(wr_col), .wr_ack(wr_ack), .pix_out(pix_out),
        .pix_vld(pix_vld), .bank(bank), .ovr(ovr), .ovr_clr(ovr_clr),
        .ram0_addr(ram0_addr), .ram0_we(ram0_we), .ram0_d(ram0_d), .ram0_q(ram0_q),
        .ram1_addr(ram1_addr), .ram1_we(ram1_we), .ram1_d(ram1_d), .ram1_q(ram1_q)
    );

    always #5 clk = ~clk;

    // Synchronous-read line buffer RAMs
    logic [CW-1:0] mem0 [256];
    logic [CW-1:0] mem1 [256];
    logic          mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= '0;
                mem1[i] <= '0;
            end
            ram0_q <= '0;
            ram1_q <= '0;
        end else begin
            if (ram0_we) mem0[ram0_addr] <= ram0_d;
            if (ram1_we) mem1[ram1_addr] <= ram1_d;
            ram0_q <= mem0[ram0_addr];
            ram1_q <= mem1[ram1_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ls, input logic pce, input logic [7:0] dx,
                         input logic cen, input logic prio, input logic wreq,
                         input logic [7:0] wx, input logic [3:0] wcol, input logic oclr);
        line_start = ls; pix_ce = pce; disp_x = dx; clear_en = cen; prio_mode = prio;
        wr_req = wreq; wr_x = wx; wr_col = wcol; ovr_clr = oclr;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One row = inputs for one cycle + outputs expected during that cycle
    typedef struct {
        logic       ls, pce;
        logic [7:0] dx;
        logic       cen, prio, wreq;
        logic [7:0] wx;
        logic [3:0] wcol;
        logic       oclr;
        logic       e_ack, e_we1;
        logic [7:0] e_addr;
        logic [3:0] e_d;
        logic       e_vld;
        logic [3:0] e_pix;
        logic       e_bank, e_ovr;
    } vec_t;
    vec_t tbl[$];

    task automatic row(input logic ls, input logic pce, input logic [7:0] dx,
                       input logic cen, input logic prio, input logic wreq,
                       input logic [7:0] wx, input logic [3:0] wcol, input logic oclr,
                       input logic e_ack, input logic e_we1, input logic [7:0] e_addr,
                       input logic [3:0] e_d, input logic e_vld, input logic [3:0] e_pix,
                       input logic e_bank, input logic e_ovr);
        vec_t v;
        v.ls = ls; v.pce = pce; v.dx = dx; v.cen = cen; v.prio = prio; v.wreq = wreq;
        v.wx = wx; v.wcol = wcol; v.oclr = oclr; v.e_ack = e_ack; v.e_we1 = e_we1;
        v.e_addr = e_addr; v.e_d = e_d; v.e_vld = e_vld; v.e_pix = e_pix;
        v.e_bank = e_bank; v.e_ovr = e_ovr;
        tbl.push_back(v);
    endtask

    // Render RMW into bank 1 (bank=0): accept, RD, WR(ack), idle
    task automatic add_wr(input logic [7:0] x, input logic [3:0] col, input logic prio,
                          input logic we);
        row(0,0,0,0,prio,1,x,col,0, 0,0,0,0,0,0,0,0);
        row(0,0,0,0,prio,1,x,col,0, 0,0,0,0,0,0,0,0);
        row(0,0,0,0,prio,1,x,col,0, 1,we,x,col,0,0,0,0);
        row(0,0,0,0,0,0,0,0,0,      0,0,0,0,0,0,0,0);
    endtask

    // Behavioural model: line buffer contents plus per-port op progress counters
    logic [CW-1:0] rbuf [2][256];
    logic          m_bank, m_pend, m_vld, m_ovr, m_dbank, m_rbank;
    logic [CW-1:0] m_pix, m_rcol;
    logic [7:0]    m_dx, m_rx;
    int            m_dcnt, m_rcnt;

    task automatic model_step();
        logic blk, dacc, racc, swp;
        chk("rnd_ack",  32'(wr_ack),  32'(m_rcnt == 2));
        chk("rnd_bank", 32'(bank),    32'(m_bank));
        chk("rnd_vld",  32'(pix_vld), 32'(m_vld));
        if (m_vld) chk("rnd_pix", 32'(pix_out), 32'(m_pix));
        chk("rnd_ovr",  32'(ovr),     32'(m_ovr));

        blk   = m_pend | line_start;
        m_vld = (m_dcnt == 2);
        if (m_dcnt == 2) begin
            m_pix = rbuf[m_dbank][m_dx];
            if (clear_en) rbuf[m_dbank][m_dx] = '0;
        end
        if (m_rcnt == 2 && m_rcol != 0 && !(prio_mode && rbuf[m_rbank][m_rx] != 0))
            rbuf[m_rbank][m_rx] = m_rcol;

        dacc = pix_ce && m_dcnt == 0 && !blk;
        racc = wr_req && m_rcnt == 0 && !blk;
        swp  = (m_pend | line_start) && m_dcnt == 0 && m_rcnt == 0;

        if (pix_ce && !dacc) m_ovr = 1'b1;
        else if (ovr_clr)    m_ovr = 1'b0;

        m_dcnt = dacc ? 1 : (m_dcnt == 1 ? 2 : 0);
        m_rcnt = racc ? 1 : (m_rcnt == 1 ? 2 : 0);
        if (dacc) begin m_dbank = m_bank;  m_dx = disp_x; end
        if (racc) begin m_rbank = !m_bank; m_rx = wr_x; m_rcol = wr_col; end
        if (swp) begin
            m_bank = !m_bank;
            m_pend = 1'b0;
        end else if (line_start) begin
            m_pend = 1'b1;
        end
    endtask

    initial begin
        logic       req_on, ack_seen;
        logic [7:0] rx;
        logic [3:0] rc;
        int         mism;

        reset_n = 1'b0;
        mem_clr = 1'b1;
        drive(0,0,0,0,0,0,0,0,0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld",   32'(pix_vld),   0);
        chk("rst_ack",   32'(wr_ack),    0);
        chk("rst_bank",  32'(bank),      0);
        chk("rst_ovr",   32'(ovr),       0);
        chk("rst_pix",   32'(pix_out),   0);
        chk("rst_we0",   32'(ram0_we),   0);
        chk("rst_we1",   32'(ram1_we),   0);
        chk("rst_addr0", 32'(ram0_addr), 0);
        chk("rst_addr1", 32'(ram1_addr), 0);
        chk("rst_d0",    32'(ram0_d),    0);
        chk("rst_d1",    32'(ram1_d),    0);
        cyc();
        reset_n = 1'b1;
        mem_clr = 1'b0;

        // Render and priority rules on bank 1
        add_wr(8'h10, 4'd5, 0, 1);
        add_wr(8'h10, 4'd3, 0, 1);
        add_wr(8'h10, 4'd7, 1, 0);
        add_wr(8'h10, 4'd0, 0, 0);
        add_wr(8'h10, 4'd7, 0, 1);
        // Swap, display read with clear, overrun and OVR_CLR behaviour
        row(1,0,0,0,0,0,0,0,0,    0,0,0,0,0,0,0,0);
        row(0,1,8'h10,1,0,0,0,0,0,0,0,0,0,0,0,1,0);
        row(0,1,8'h10,1,0,0,0,0,0,0,0,0,0,0,0,1,0);
        row(0,0,0,1,0,0,0,0,0,    0,1,8'h10,0,0,0,1,1);
        row(0,0,0,0,0,0,0,0,0,    0,0,0,0,1,7,1,1);
        row(0,0,0,0,0,0,0,0,0,    0,0,0,0,0,0,1,1);
        row(0,0,0,0,0,0,0,0,1,    0,0,0,0,0,0,1,1);
        row(0,0,0,0,0,0,0,0,0,    0,0,0,0,0,0,1,0);
        row(0,1,8'h10,1,0,0,0,0,0,0,0,0,0,0,0,1,0);
        row(0,1,8'h10,1,0,0,0,0,1,0,0,0,0,0,0,1,0);
        row(0,0,0,1,0,0,0,0,0,    0,1,8'h10,0,0,0,1,1);
        row(0,0,0,0,0,0,0,0,0,    0,0,0,0,1,0,1,1);
        row(0,0,0,0,0,0,0,0,1,    0,0,0,0,0,0,1,1);
        row(0,0,0,0,0,0,0,0,0,    0,0,0,0,0,0,1,0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc();
            drive(tbl[i].ls, tbl[i].pce, tbl[i].dx, tbl[i].cen, tbl[i].prio,
                  tbl[i].wreq, tbl[i].wx, tbl[i].wcol, tbl[i].oclr);
            @(negedge clk);
            chk($sformatf("t%0d_ack", i),  32'(wr_ack),  32'(tbl[i].e_ack));
            chk($sformatf("t%0d_we0", i),  32'(ram0_we), 0);
            chk($sformatf("t%0d_we1", i),  32'(ram1_we), 32'(tbl[i].e_we1));
            if (tbl[i].e_we1) begin
                chk($sformatf("t%0d_addr", i), 32'(ram1_addr), 32'(tbl[i].e_addr));
                chk($sformatf("t%0d_d", i),    32'(ram1_d),    32'(tbl[i].e_d));
            end
            chk($sformatf("t%0d_vld", i),  32'(pix_vld), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) chk($sformatf("t%0d_pix", i), 32'(pix_out), 32'(tbl[i].e_pix));
            chk($sformatf("t%0d_bank", i), 32'(bank),    32'(tbl[i].e_bank));
            chk($sformatf("t%0d_ovr", i),  32'(ovr),     32'(tbl[i].e_ovr));
        end

        // Swap requested during render RD: write stays on old render bank (0)
        cyc(); drive(0,0,0,0,0,1,8'h33,4'd9,0);
        @(negedge clk); chk("sw_bank_a", 32'(bank), 1);
        cyc(); drive(1,0,0,0,0,1,8'h33,4'd9,0);
        cyc(); drive(0,0,0,0,0,1,8'h33,4'd9,0);
        @(negedge clk);
        chk("sw_ack_old",  32'(wr_ack),    1);
        chk("sw_we0",      32'(ram0_we),   1);
        chk("sw_addr0",    32'(ram0_addr), 32'h33);
        chk("sw_d0",       32'(ram0_d),    9);
        chk("sw_bank_wr",  32'(bank),      1);
        cyc(); drive(0,0,0,0,0,1,8'h44,4'd2,0);
        @(negedge clk);
        chk("sw_bank_hold", 32'(bank),   1);
        chk("sw_noack",     32'(wr_ack), 0);
        cyc();
        @(negedge clk); chk("sw_bank_new", 32'(bank), 0);
        cyc();
        @(negedge clk); chk("sw_rd_noack", 32'(wr_ack), 0);
        cyc();
        @(negedge clk);
        chk("sw_ack_new", 32'(wr_ack),    1);
        chk("sw_we1",     32'(ram1_we),   1);
        chk("sw_addr1",   32'(ram1_addr), 32'h44);
        chk("sw_d1",      32'(ram1_d),    2);
        cyc(); drive(0,0,0,0,0,0,0,0,0);
        @(negedge clk);
        chk("sw_mem0", 32'(mem0[8'h33]), 9);
        chk("sw_mem1", 32'(mem1[8'h44]), 2);

        // Reset in the middle of a render RMW and a display read
        cyc(); drive(0,1,8'h20,1,0,1,8'h55,4'd6,0);
        cyc(); drive(0,1,8'h20,1,0,1,8'h55,4'd6,0);
        cyc(); drive(0,0,0,1,0,1,8'h55,4'd6,0);
        chk("mr_pre_ack", 32'(wr_ack), 1);
        chk("mr_pre_ovr", 32'(ovr),    1);
        reset_n = 1'b0;
        #1;
        chk("mr_we0", 32'(ram0_we), 0);
        chk("mr_we1", 32'(ram1_we), 0);
        chk("mr_ack", 32'(wr_ack),  0);
        chk("mr_ovr", 32'(ovr),     0);
        chk("mr_vld", 32'(pix_vld), 0);
        cyc(); drive(0,0,0,0,0,0,0,0,0);
        cyc(); reset_n = 1'b1;
        @(negedge clk);
        chk("mr_bank", 32'(bank),        0);
        chk("mr_ovr2", 32'(ovr),         0);
        chk("mr_vld2", 32'(pix_vld),     0);
        chk("mr_mem1", 32'(mem1[8'h55]), 0);

        // Randomized traffic against the model
        for (int b = 0; b < 256; b++) begin
            rbuf[0][b] = mem0[b];
            rbuf[1][b] = mem1[b];
        end
        m_bank = 0; m_pend = 0; m_vld = 0; m_ovr = 0; m_dcnt = 0; m_rcnt = 0;
        m_pix = '0; m_rcol = '0; m_dx = '0; m_rx = '0; m_dbank = 0; m_rbank = 1;
        req_on = 0; ack_seen = 0; rx = '0; rc = '0;
        for (int c = 0; c < 3012; c++) begin
            cyc();
            if (req_on && ack_seen) req_on = 0;
            if (!req_on && c < 3000 && $urandom_range(0, 1) == 1) begin
                req_on = 1;
                rx = 8'($urandom_range(0, 15));
                rc = 4'($urandom_range(0, 15));
            end
            drive(c < 3000 && $urandom_range(0, 15) == 0,
                  c < 3000 && $urandom_range(0, 2) == 0,
                  8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), req_on, rx, rc,
                  $urandom_range(0, 7) == 0);
            @(negedge clk);
            ack_seen = wr_ack;
            model_step();
        end
        chk("rnd_req_retired", 32'(req_on && !ack_seen), 0);
        cyc(); drive(0,0,0,0,0,0,0,0,0);
        repeat (2) cyc();
        for (int bk = 0; bk < 2; bk++) begin
            mism = 0;
            for (int b = 0; b < 256; b++)
                if ((bk == 0 ? mem0[b] : mem1[b]) !== rbuf[bk][b]) mism++;
            chk($sformatf("rnd_mem%0d_mismatches", bk), 32'(mism), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
